// File: rtl/display_scheduler.sv
// Chooses what the four-digit display shows: timed page rotation, or a fixed hold window for one requester.
// Define DISPLAY_SCHED_FREEZE_EN to show a snapshot of the granted source for the whole window.
module display_scheduler #(
    parameter int DWELL_BITS = 24,
    parameter int HOLD_BITS  = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] src_data,
    input  logic [3:0]  req,
    input  logic        auto_en,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic [1:0]  page,
    output logic [15:0] num
);

    typedef enum logic {
        ST_ROTATE = 1'b0,
        ST_SERVE  = 1'b1
    } state_t;

    state_t                state_q,  state_d;
    logic [1:0]            rr_q,     rr_d;
    logic [1:0]            page_q,   page_d;
    logic [DWELL_BITS-1:0] dwell_q,  dwell_d;
    logic [HOLD_BITS-1:0]  hold_q,   hold_d;
    logic [3:0]            grant_q,  grant_d;
    logic [15:0]           num_q,    num_d;
`ifdef DISPLAY_SCHED_FREEZE_EN
    logic [15:0]           snap_q,   snap_d;
`endif

    logic       hold_term;
    logic       dwell_term;
    logic       serve_end;
    logic       arb_enable;
    logic [1:0] serve_idx;
    logic [1:0] arb_base;
    logic [1:0] arb_cand;
    logic [1:0] arb_idx;
    logic       arb_found;

    function automatic logic [15:0] word_of(input logic [63:0] data, input logic [1:0] idx);
        logic [15:0] w;
        case (idx)
            2'd0:    w = data[15:0];
            2'd1:    w = data[31:16];
            2'd2:    w = data[47:32];
            default: w = data[63:48];
        endcase
        return w;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] i;
        case (oh)
            4'b0010: i = 2'd1;
            4'b0100: i = 2'd2;
            4'b1000: i = 2'd3;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

    assign hold_term  = (hold_q == {HOLD_BITS{1'b1}});
    assign dwell_term = (dwell_q == {DWELL_BITS{1'b1}});
    assign serve_idx  = onehot_idx(grant_q);
    assign serve_end  = (state_q == ST_SERVE) && hold_term;
    assign arb_enable = (state_q == ST_ROTATE) || serve_end;

    // In the last hold cycle the pointer has not been written yet, so the search starts just past the source being served.
    assign arb_base = serve_end ? (serve_idx + 2'd1) : rr_q;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 2'd0;
        arb_cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            arb_cand = arb_base + 2'(k);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        page_d  = page_q;
        dwell_d = dwell_q;
        hold_d  = hold_q;
        grant_d = grant_q;
`ifdef DISPLAY_SCHED_FREEZE_EN
        snap_d  = snap_q;
        num_d   = (state_q == ST_SERVE) ? snap_q : word_of(src_data, page_q);
`else
        num_d   = (state_q == ST_SERVE) ? word_of(src_data, serve_idx)
                                        : word_of(src_data, page_q);
`endif

        case (state_q)
            ST_ROTATE: begin
                if (auto_en) begin
                    if (dwell_term) begin
                        dwell_d = '0;
                        page_d  = page_q + 2'd1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end else begin
                    dwell_d = '0;
                end
            end
            ST_SERVE: begin
                hold_d = hold_q + 1'b1;
                if (hold_term) begin
                    rr_d    = serve_idx + 2'd1;
                    grant_d = 4'b0000;
                    state_d = ST_ROTATE;
                end
            end
            default: state_d = ST_ROTATE;
        endcase

        if (arb_enable && arb_found) begin
            state_d = ST_SERVE;
            grant_d = 4'b0001 << arb_idx;
            hold_d  = '0;
`ifdef DISPLAY_SCHED_FREEZE_EN
            snap_d  = word_of(src_data, arb_idx);
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_ROTATE;
            rr_q    <= 2'd0;
            page_q  <= 2'd0;
            dwell_q <= '0;
            hold_q  <= '0;
            grant_q <= 4'b0000;
            num_q   <= 16'h0000;
`ifdef DISPLAY_SCHED_FREEZE_EN
            snap_q  <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            page_q  <= page_d;
            dwell_q <= dwell_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            num_q   <= num_d;
`ifdef DISPLAY_SCHED_FREEZE_EN
            snap_q  <= snap_d;
`endif
        end
    end

    // The ack decode comes straight from flops so it coincides with the final grant cycle and clears with reset.
    assign ack   = serve_end ? grant_q : 4'b0000;
    assign grant = grant_q;
    assign page  = page_q;
    assign num   = num_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized scoreboard bench for display_scheduler with a cycle-level behavioural reference model.
module tb_display_scheduler;

    localparam int DWELL_LEN = 8;
    localparam int HOLD_LEN  = 4;
    localparam logic [63:0] DEFAULT_SRC = 64'h4444_3333_2222_1111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] srcData = DEFAULT_SRC;
    logic [3:0]  req = 4'b0000;
    logic        autoEn = 1'b0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [1:0]  page;
    logic [15:0] num;

    display_scheduler #(.DWELL_BITS(3), .HOLD_BITS(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .src_data (srcData),
        .req      (req),
        .auto_en  (autoEn),
        .grant    (grant),
        .ack      (ack),
        .page     (page),
        .num      (num)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic [1:0]  page;
        logic [15:0] num;
    } exp_t;

    exp_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: what is being shown, expressed as plain integers.
    bit          mServing = 0;
    int          mSrv = 0;
    int          mHeld = 0;
    int          mDwell = 0;
    int          mPage = 0;
    int          mRr = 0;
    logic [15:0] mNum = 16'h0;
    logic [15:0] mSnap = 16'h0;

    function automatic logic [15:0] wordOf(input logic [63:0] s, input int j);
        return s[16*j +: 16];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    function automatic exp_t modelOutputs();
        exp_t e;
        e.grant = mServing ? 4'(1 << mSrv) : 4'b0000;
        e.ack   = (mServing && mHeld == HOLD_LEN - 1) ? e.grant : 4'b0000;
        e.page  = 2'(mPage);
        e.num   = mNum;
        return e;
    endfunction

    task automatic modelArbitrate(input logic [3:0] r, input logic [63:0] s);
        mServing = 0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (mRr + k) % 4;
            if (!mServing && r[j]) begin
                mServing = 1;
                mSrv     = j;
                mHeld    = 0;
                mSnap    = wordOf(s, j);
            end
        end
    endtask

    task automatic modelStep(input logic rst, input logic [3:0] r, input logic a, input logic [63:0] s);
        logic [15:0] nextNum;
        if (rst) begin
            mServing = 0; mSrv = 0; mHeld = 0; mDwell = 0;
            mPage = 0; mRr = 0; mNum = 16'h0; mSnap = 16'h0;
            return;
        end
`ifdef DISPLAY_SCHED_FREEZE_EN
        nextNum = mServing ? mSnap : wordOf(s, mPage);
`else
        nextNum = mServing ? wordOf(s, mSrv) : wordOf(s, mPage);
`endif
        if (mServing) begin
            if (mHeld == HOLD_LEN - 1) begin
                mRr = (mSrv + 1) % 4;
                modelArbitrate(r, s);
            end else begin
                mHeld++;
            end
        end else begin
            if (a) begin
                if (mDwell == DWELL_LEN - 1) begin
                    mDwell = 0;
                    mPage  = (mPage + 1) % 4;
                end else begin
                    mDwell++;
                end
            end else begin
                mDwell = 0;
            end
            modelArbitrate(r, s);
        end
        mNum = nextNum;
    endtask

    // One clock of stimulus; a newly asserted reset is also checked for its immediate, clockless effect.
    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic a, input logic [63:0] s);
        @(negedge clock);
        req     = r;
        autoEn  = a;
        srcData = s;
        if (rst && !reset) begin
            reset = 1'b1;
            #1;
            checkOutput("async_grant", {28'h0, grant}, 32'h0);
            checkOutput("async_ack",   {28'h0, ack},   32'h0);
            checkOutput("async_page",  {30'h0, page},  32'h0);
            checkOutput("async_num",   {16'h0, num},   32'h0);
        end else begin
            reset = rst;
        end
        modelStep(rst, r, a, s);
        expQ.push_back(modelOutputs());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("grant", {28'h0, grant}, {28'h0, e.grant});
                checkOutput("ack",   {28'h0, ack},   {28'h0, e.ack});
                checkOutput("page",  {30'h0, page},  {30'h0, e.page});
                checkOutput("num",   {16'h0, num},   {16'h0, e.num});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [63:0] s;
        logic [3:0]  r;

        // Reset and free rotation through all four pages and back to page 0.
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b1, DEFAULT_SRC);
        repeat (40) applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);

        // Rotation disabled: page and num must hold.
        repeat (50) applyStimulus(1'b0, 4'b0000, 1'b0, DEFAULT_SRC);

        // Single request dropped after one cycle still gets its full window, then rotation resumes.
        repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);
        applyStimulus(1'b0, 4'b0100, 1'b1, DEFAULT_SRC);
        repeat (14) applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);

        // Simultaneous requests from a fresh pointer: back-to-back grants 0, 3, 0, 3.
        applyStimulus(1'b1, 4'b0000, 1'b1, DEFAULT_SRC);
        repeat (16) applyStimulus(1'b0, 4'b1001, 1'b1, DEFAULT_SRC);
        repeat (6) applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);

        // Reset asserted in the second serve cycle; the held request is re-served after release.
        applyStimulus(1'b0, 4'b0010, 1'b1, DEFAULT_SRC);
        applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);
        applyStimulus(1'b1, 4'b0010, 1'b1, DEFAULT_SRC);
        applyStimulus(1'b1, 4'b0010, 1'b1, DEFAULT_SRC);
        applyStimulus(1'b0, 4'b0010, 1'b1, DEFAULT_SRC);
        repeat (8) applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);

        // Granted source changes mid-window: live or frozen depending on the build.
        applyStimulus(1'b0, 4'b0100, 1'b1, DEFAULT_SRC);
        applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);
        repeat (6) applyStimulus(1'b0, 4'b0000, 1'b1, 64'h4444_BEEF_2222_1111);
        repeat (4) applyStimulus(1'b0, 4'b0000, 1'b1, DEFAULT_SRC);

        // Randomized traffic: sparse requests, occasional rotation stalls, source changes and resets.
        s = DEFAULT_SRC;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) s[16*$urandom_range(0, 3) +: 16] = 16'($urandom);
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            applyStimulus($urandom_range(0, 79) == 0, r, $urandom_range(0, 5) != 0, s);
        end

        repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1, s);
        @(negedge clock);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Schedules what the four-digit seven-segment display shows. Four 16-bit sources compete for the display. With no requests pending, the block rotates through the sources page by page. A requester can raise `req` to take over the display for a fixed hold window, and receives an `ack` pulse when that window ends. The registered `num` output drives the `num` input of the display multiplexer.

## Interface
Parameters:
- `DWELL_BITS`, default 24: page dwell time in rotate mode is 2^DWELL_BITS cycles.
- `HOLD_BITS`, default 26: length of a served request is 2^HOLD_BITS cycles.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `src_data`  in  64  four packed 16-bit sources; source i occupies bits [16i+15:16i].
- `req`  in  4  level request per source; bit i means source i wants the display.
- `auto_en`  in  1  enables page rotation while no request is being served.
- `grant`  out  4  one-hot; shows the source currently being served; 0 in rotate mode.
- `ack`  out  4  one-cycle pulse on bit i at the end of the hold window for source i.
- `page`  out  2  current rotate-mode page index.
- `num`  out  16  value to display, registered.

## Operation
- Reset values: `grant`=0, `ack`=0, `page`=0, `num`=0, state ROTATE, round-robin pointer `rr`=0, dwell and hold counters 0.
- **ROTATE state:**
  - `num` follows source `page`.
  - While `auto_en`=1, the dwell counter increments. At terminal count (2^DWELL_BITS−1), `page` increments (3 wraps to 0) and the counter clears.
  - While `auto_en`=0, the dwell counter clears and `page` holds.
- **Arbitration:**
  - Runs whenever the state is ROTATE, or in the last hold cycle of SERVE.
  - The winner is the first set `req` bit searching upward from `rr` (modulo 4).
  - A winner loads `grant`, clears the hold counter, and enters SERVE.
- **SERVE state:**
  - `num` follows the granted source.
  - The hold counter increments every cycle. The dwell counter and `page` are frozen.
- **End of hold window:**
  - When the hold counter reaches terminal count, `ack[i]` pulses together with the last `grant` cycle.
  - `rr` becomes i+1 (mod 4).
  - Re-arbitration happens in the same cycle. If any `req` bit is set, the next grant follows back-to-back with no ROTATE cycle. Otherwise the block returns to ROTATE and resumes the dwell count where it was paused.
- **Request rules:**
  - Requests are levels. A requester still high after its `ack` is eligible again, but at lowest priority.
  - Dropping `req` mid-SERVE does not shorten the window. The serve runs to completion and still acks.
- **Reset mid-operation:** all outputs return immediately to their reset values. No `ack` is issued for the aborted serve. Requests still high are re-arbitrated after reset is released.

## Timing
- `req` first sampled high at edge t while in ROTATE: `grant` asserts after edge t, and `num` shows the granted source after edge t+1 (one cycle of select-to-data latency).
- `grant` stays high for exactly 2^HOLD_BITS cycles. `ack` is high only in the final one of those cycles.
- A source change in rotate or live serve appears on `num` one cycle later.
- A page advance appears on `num` one cycle after `page` changes.
- Asynchronous reset clears outputs without waiting for a clock edge. Release is synchronous to `clock`.

## Configuration
- `DISPLAY_SCHED_FREEZE_EN` defined:
  - At grant, the granted source is captured into a snapshot register.
  - `num` shows the snapshot for the whole SERVE window, ignoring later source changes.
  - Back-to-back grants capture a fresh snapshot.
- Not defined: `num` tracks the granted source live during SERVE.
- Rotate-mode behaviour is identical in both builds.

## Test plan
Test parameters: DWELL_BITS=3, HOLD_BITS=2. Sources: `src_data` = {0x4444, 0x3333, 0x2222, 0x1111}.
- **Reset and rotation:** reset, then `auto_en`=1, no `req` → `num`=0x1111. After 8 cycles `page`=1 and `num`=0x2222 the next cycle. After 32 cycles `page` has wrapped to 0.
- **Rotation disabled:** `auto_en`=0 for 50 cycles → `page` stays constant and `num` stays constant.
- **Single request:** `req`=0100 held → `grant`=0100 for exactly 4 cycles and `num`=0x3333. `ack`=0100 in the 4th cycle only. Then ROTATE resumes with the paused dwell count intact.
- **Simultaneous requests:** `req`=1001 with `rr`=0 → `grant`=0001 for 4 cycles, then `grant`=1000 immediately with no gap. The two `ack` pulses are 4 cycles apart.
- **Reset mid-serve:** assert `reset` in the 2nd SERVE cycle → `grant`, `ack`, `num` and `page` are 0 immediately, and no `ack` is issued.
- **Freeze build:** with `DISPLAY_SCHED_FREEZE_EN`, serve source 2 and change it to 0xBEEF mid-window → `num` stays 0x3333 until the window ends. Without the macro, `num`=0xBEEF one cycle after the change.
